// File: rtl/req_err_pkg.sv
// Shared defaults and channel index constants for the request-checker
// error-capture block.
//   DATA_W_DEF / NCH_DEF / CNT_W_DEF : default word width, channel count, counter width
//   CH_*                             : channel index constants at the default NCH
package req_err_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned NCH_DEF    = 4;
   localparam int unsigned CNT_W_DEF  = 16;

   localparam int unsigned CH_EVT  = 0;
   localparam int unsigned CH_HDR1 = 1;
   localparam int unsigned CH_HDR2 = 2;
   localparam int unsigned CH_DATA = 3;

endpackage

// File: rtl/req_err_chan.sv
// One checked channel: compare, first-mismatch capture, sticky flag and
// saturating mismatch counter.
//   clk, reset          : clock, asynchronous active-high reset
//   err_clear           : synchronous clear, wins over a same-cycle mismatch
//   chk_valid           : compare strobe
//   expc, seen          : expected / observed word
//   mismatch_c          : combinational mismatch indication for this cycle
//   flag                : sticky error flag
//   cap_expc, cap_seen  : first mismatching pair
//   cnt                 : saturating mismatch count
module req_err_chan
   import req_err_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              err_clear,
   input  logic              chk_valid,
   input  logic [DATA_W-1:0] expc,
   input  logic [DATA_W-1:0] seen,
   output logic              mismatch_c,
   output logic              flag,
   output logic [DATA_W-1:0] cap_expc,
   output logic [DATA_W-1:0] cap_seen,
   output logic [CNT_W-1:0]  cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   assign mismatch_c = chk_valid && (expc != seen);

   // Capture only while the flag is still clear; count every mismatch up to CNT_MAX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag     <= 1'b0;
         cap_expc <= '0;
         cap_seen <= '0;
         cnt      <= '0;
      end else if (err_clear) begin
         flag     <= 1'b0;
         cap_expc <= '0;
         cap_seen <= '0;
         cnt      <= '0;
      end else if (mismatch_c) begin
         if (!flag) begin
            cap_expc <= expc;
            cap_seen <= seen;
         end
         flag <= 1'b1;
         if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/req_err_capture.sv
// Error capture for NCH expected/observed channels with first-error ordering
// and a registered readback port.
//   clk, reset          : clock, asynchronous active-high reset
//   chk_valid           : per-channel compare strobe
//   expc, seen          : packed expected / observed words, channel i at [i*DATA_W +: DATA_W]
//   err_clear           : synchronous clear of all captured state
//   err_sel             : readback channel select
//   expc_err, seen_err  : captured pair of the selected channel (0 if err_sel >= NCH)
//   err_cnt             : mismatch count of the selected channel (0 if err_sel >= NCH)
//   err_flag            : sticky per-channel flags
//   err_any             : registered OR of err_flag
//   first_ch            : first channel to err since reset/clear
//   first_valid         : first_ch is valid
module req_err_capture
   import req_err_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NCH    = NCH_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned SEL_W  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NCH-1:0]        chk_valid,
   input  logic [NCH*DATA_W-1:0] expc,
   input  logic [NCH*DATA_W-1:0] seen,
   input  logic                  err_clear,
   input  logic [SEL_W-1:0]      err_sel,
   output logic [DATA_W-1:0]     expc_err,
   output logic [DATA_W-1:0]     seen_err,
   output logic [CNT_W-1:0]      err_cnt,
   output logic [NCH-1:0]        err_flag,
   output logic                  err_any,
   output logic [SEL_W-1:0]      first_ch,
   output logic                  first_valid
);

   logic [NCH-1:0]    mis_c;
   logic [DATA_W-1:0] cap_expc [NCH];
   logic [DATA_W-1:0] cap_seen [NCH];
   logic [CNT_W-1:0]  cap_cnt  [NCH];
   logic [SEL_W-1:0]  first_idx_c;
   logic [DATA_W-1:0] rb_expc_c;
   logic [DATA_W-1:0] rb_seen_c;
   logic [CNT_W-1:0]  rb_cnt_c;

   // Per-channel compare and capture.
   for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
      req_err_chan #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .err_clear  (err_clear),
         .chk_valid  (chk_valid[g]),
         .expc       (expc[g*DATA_W +: DATA_W]),
         .seen       (seen[g*DATA_W +: DATA_W]),
         .mismatch_c (mis_c[g]),
         .flag       (err_flag[g]),
         .cap_expc   (cap_expc[g]),
         .cap_seen   (cap_seen[g]),
         .cnt        (cap_cnt[g])
      );
   end

   // Lowest mismatching index wins; scanning downward leaves the lowest one last.
   always_comb begin
      first_idx_c = '0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (mis_c[i]) begin
            first_idx_c = SEL_W'(i);
         end
      end
   end

   // Readback select; an out-of-range err_sel matches no channel and yields 0.
   always_comb begin
      rb_expc_c = '0;
      rb_seen_c = '0;
      rb_cnt_c  = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (err_sel == SEL_W'(i)) begin
            rb_expc_c = cap_expc[i];
            rb_seen_c = cap_seen[i];
            rb_cnt_c  = cap_cnt[i];
         end
      end
   end

   // First-error latch, err_any stage and readback registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first_ch    <= '0;
         first_valid <= 1'b0;
         err_any     <= 1'b0;
         expc_err    <= '0;
         seen_err    <= '0;
         err_cnt     <= '0;
      end else if (err_clear) begin
         first_ch    <= '0;
         first_valid <= 1'b0;
         err_any     <= 1'b0;
         expc_err    <= '0;
         seen_err    <= '0;
         err_cnt     <= '0;
      end else begin
         if (!first_valid && (|mis_c)) begin
            first_ch    <= first_idx_c;
            first_valid <= 1'b1;
         end
         err_any  <= |err_flag;
         expc_err <= rb_expc_c;
         seen_err <= rb_seen_c;
         err_cnt  <= rb_cnt_c;
      end
   end

endmodule
